// File: rtl/bht_predictor.sv
// bht_predictor: fetch-side next-PC predictor with a branch counter table and JALR stall.
//   clk, rst_n             clock, asynchronous active-low reset
//   rdy                    global ready, low freezes every register and counter
//   flush                  misprediction flush, drops fetch/JALR input and returns to IDLE
//   if_valid/if_pc/if_instr      fetched instruction to predict
//   pred_valid/pred_is_jump/pred_taken/pred_pc/stall_if   registered prediction, one cycle later
//   upd_valid/upd_pc/upd_taken   committed branch outcome used for training
//   jalr_valid/jalr_target       resolved JALR target from the ALU
//   cnt_lookups/cnt_mispred      branch lookup and commit-time misprediction statistics
module bht_predictor #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [31:0]       if_instr,
  output logic              pred_valid,
  output logic              pred_is_jump,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              stall_if,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              jalr_valid,
  input  logic [ADDR_W-1:0] jalr_target,
  output logic [31:0]       cnt_lookups,
  output logic [31:0]       cnt_mispred
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  typedef enum logic {IDLE, WAIT_JALR} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt_tbl [2**INDEX_W];
  logic [INDEX_W-1:0] look_idx, upd_idx;
  logic [CNT_W-1:0] look_cnt, upd_old, upd_new;
  logic signed [20:0] j_imm;
  logic signed [12:0] b_imm;
  logic signed [ADDR_W-1:0] j_ext, b_ext;
  logic valid_n, jump_n, taken_n, stall_n, lookup;
  logic [ADDR_W-1:0] pc_n;
  logic [6:0] opc;
  assign opc      = if_instr[6:0];
  assign look_idx = if_pc[INDEX_W+1:2];
  assign upd_idx  = upd_pc[INDEX_W+1:2];
  assign look_cnt = cnt_tbl[look_idx];
  assign upd_old  = cnt_tbl[upd_idx];
  assign upd_new  = upd_taken ? (upd_old == CNT_MAX ? upd_old : upd_old + CNT_W'(1))
                              : (upd_old == '0 ? upd_old : upd_old - CNT_W'(1));
  assign j_imm    = {if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
  assign b_imm    = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign j_ext    = ADDR_W'(j_imm);
  assign b_ext    = ADDR_W'(b_imm);
  // Non-valid cycles keep the last prediction fields; only pred_valid drops.
  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    jump_n  = pred_is_jump;
    taken_n = pred_taken;
    pc_n    = pred_pc;
    stall_n = stall_if;
    lookup  = 1'b0;
    if (flush) begin
      stall_n = 1'b0;
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (if_valid) begin
        valid_n = opc != OP_JALR;
        jump_n  = opc == OP_JAL || opc == OP_BR || opc == OP_JALR;
        taken_n = opc == OP_JAL || opc == OP_JALR || (opc == OP_BR && look_cnt[CNT_W-1]);
        lookup  = opc == OP_BR;
        stall_n = opc == OP_JALR;
        state_n = opc == OP_JALR ? WAIT_JALR : IDLE;
        pc_n    = opc == OP_JALR ? pred_pc
                : opc == OP_JAL  ? if_pc + j_ext
                : (opc == OP_BR && look_cnt[CNT_W-1]) ? if_pc + b_ext
                : if_pc + ADDR_W'(4);
      end
    end else if (jalr_valid) begin
      valid_n = 1'b1;
      jump_n  = 1'b1;
      taken_n = 1'b1;
      pc_n    = jalr_target;
      stall_n = 1'b0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pred_valid   <= 1'b0;
      pred_is_jump <= 1'b0;
      pred_taken   <= 1'b0;
      pred_pc      <= '0;
      stall_if     <= 1'b0;
      cnt_lookups  <= '0;
      cnt_mispred  <= '0;
    end else if (rdy) begin
      state        <= state_n;
      pred_valid   <= valid_n;
      pred_is_jump <= jump_n;
      pred_taken   <= taken_n;
      pred_pc      <= pc_n;
      stall_if     <= stall_n;
      cnt_lookups  <= cnt_lookups + 32'(lookup);
      cnt_mispred  <= cnt_mispred + 32'(upd_valid && (upd_old[CNT_W-1] != upd_taken));
    end
  end
  // The lookup reads the table combinationally, so a same-cycle update is seen only afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**INDEX_W; i++) cnt_tbl[i] <= CNT_W'(INIT_CNT);
    end else if (rdy && upd_valid) begin
      cnt_tbl[upd_idx] <= upd_new;
    end
  end
endmodule
